// File: rtl/dcnt16_if.sv
// dcnt16_if -- control/status bundle for the dcnt16 down-counter.
//
// Signals:
//   start   load ld_val and begin counting down
//   ld_val  start value, sampled only on an accepted start
//   en      count-down enable while running
//   stop    abort the run, count holds
//   q       current count (registered)
//   busy    high while running (registered)
//   tc      one-cycle terminal-count pulse (registered)
//   zero    combinational flag, high when q == 0
//
// Modports: master drives the controls, slave is the counter itself.

interface dcnt16_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] ld_val;
    logic             en;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;
    logic             zero;

    modport master (
        output start, ld_val, en, stop,
        input  q, busy, tc, zero
    );

    modport slave (
        input  start, ld_val, en, stop,
        output q, busy, tc, zero
    );
endinterface

// File: rtl/dcnt16.sv
// dcnt16 -- loadable down-counter with terminal-count pulse.
//
// Ports:
//   clk  single clock, all state changes on its rising edge
//   rst  asynchronous, active-high reset
//   bus  dcnt16_if.slave (start, ld_val, en, stop in; q, busy, tc, zero out)
//
// Input priority per edge is start > stop > en. A zero-valued start
// produces an immediate terminal pulse and leaves the counter idle.
//
// Optional feature (macro DCNT16_RELOAD_EN): start also captures ld_val
// into a reload register, and reaching the terminal count reloads q and
// stays running (periodic mode). Only stop, reset or a zero-valued start
// leave periodic mode.
//
// state | meaning
// IDLE  | not counting, q holds, busy = 0
// RUN   | counting down on en, busy = 1

module dcnt16 #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    dcnt16_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic             busy_r;
    logic             tc_r;

`ifdef DCNT16_RELOAD_EN
    logic [WIDTH-1:0] reload_r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            q_r    <= '0;
            busy_r <= 1'b0;
            tc_r   <= 1'b0;
`ifdef DCNT16_RELOAD_EN
            reload_r <= '0;
`endif
        end else if (bus.start) begin
`ifdef DCNT16_RELOAD_EN
            reload_r <= bus.ld_val;
`endif
            if (bus.ld_val != '0) begin
                q_r    <= bus.ld_val;
                state  <= RUN;
                busy_r <= 1'b1;
                tc_r   <= 1'b0;
            end else begin
                // Zero load is already at terminal count: pulse now, stay idle.
                q_r    <= '0;
                state  <= IDLE;
                busy_r <= 1'b0;
                tc_r   <= 1'b1;
            end
        end else if (bus.stop && state == RUN) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            tc_r   <= 1'b0;
        end else if (state == RUN && bus.en) begin
            if (q_r == ONE) begin
                tc_r <= 1'b1;
`ifdef DCNT16_RELOAD_EN
                q_r  <= reload_r;
`else
                q_r    <= '0;
                state  <= IDLE;
                busy_r <= 1'b0;
`endif
            end else begin
                tc_r <= 1'b0;
                // q == 0 cannot occur while running; guard keeps it from wrapping.
                if (q_r != '0) begin
                    q_r <= q_r - ONE;
                end
            end
        end else begin
            tc_r <= 1'b0;
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = busy_r;
    assign bus.tc   = tc_r;
    assign bus.zero = (q_r == '0);

endmodule

// File: tb/tb_dcnt16.sv
module tb_dcnt16;
    localparam int WIDTH = 16;
`ifdef DCNT16_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dcnt16_if #(.WIDTH(WIDTH)) bus ();

    dcnt16 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.en     = 1'b0;
        bus.ld_val = '0;
        #3;
        total++;
        if ({bus.q, bus.busy, bus.tc, bus.zero} !== {16'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: q=%0d busy=%0b tc=%0b zero=%0b, want q=0 busy=0 tc=0 zero=1",
                     bus.q, bus.busy, bus.tc, bus.zero);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.en = 1'b1;
        step();
        step();
        total++;
        if ({bus.q, bus.busy, bus.tc} !== {16'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL idle_after_reset: q=%0d busy=%0b tc=%0b, want 0 0 0", bus.q, bus.busy, bus.tc);
        end
    endtask

    task automatic test_basic();
        logic [15:0] eq;
        logic        etc, eb;
        bus.ld_val = 16'd5;
        bus.start  = 1'b1;
        bus.en     = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if ({bus.q, bus.busy, bus.tc} !== {16'd5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL basic_load: q=%0d busy=%0b tc=%0b, want 5 1 0", bus.q, bus.busy, bus.tc);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            eq  = (i == 5) ? (RELOAD ? 16'd5 : 16'd0) : 16'(5 - i);
            etc = (i == 5);
            eb  = (i < 5) ? 1'b1 : RELOAD;
            total++;
            if ({bus.q, bus.tc, bus.busy, bus.zero} !== {eq, etc, eb, (eq == 16'd0)}) begin
                bad++;
                $display("FAIL basic_count[%0d]: q=%0d tc=%0b busy=%0b zero=%0b, want q=%0d tc=%0b busy=%0b zero=%0b",
                         i, bus.q, bus.tc, bus.busy, bus.zero, eq, etc, eb, (eq == 16'd0));
            end
        end
        bus.en = 1'b0;
        step();
        total++;
        if ({bus.q, bus.tc} !== {(RELOAD ? 16'd5 : 16'd0), 1'b0}) begin
            bad++;
            $display("FAIL basic_tc_width: q=%0d tc=%0b, want tc=0", bus.q, bus.tc);
        end
    endtask

    task automatic test_en_toggle();
        logic [15:0] exp_q [7] = '{16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd0};
        logic [15:0] eq;
        bus.ld_val = 16'd4;
        bus.start  = 1'b1;
        bus.en     = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if ({bus.q, bus.busy} !== {16'd4, 1'b1}) begin
            bad++;
            $display("FAIL toggle_load: q=%0d busy=%0b, want 4 1", bus.q, bus.busy);
        end
        for (int i = 1; i <= 7; i++) begin
            bus.en = (i % 2) == 1;
            step();
            eq = (i == 7 && RELOAD) ? 16'd4 : exp_q[i-1];
            total++;
            if ({bus.q, bus.tc, bus.busy} !== {eq, (i == 7), ((i < 7) ? 1'b1 : RELOAD)}) begin
                bad++;
                $display("FAIL toggle_count[%0d]: q=%0d tc=%0b busy=%0b, want q=%0d tc=%0b",
                         i, bus.q, bus.tc, bus.busy, eq, (i == 7));
            end
        end
        bus.en = 1'b0;
        step();
        total++;
        if (bus.tc !== 1'b0) begin
            bad++;
            $display("FAIL toggle_tc_width: tc=%0b, want 0", bus.tc);
        end
    endtask

    task automatic test_zero_start();
        bus.ld_val = 16'd0;
        bus.start  = 1'b1;
        bus.en     = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if ({bus.q, bus.tc, bus.busy, bus.zero} !== {16'd0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL zero_start: q=%0d tc=%0b busy=%0b zero=%0b, want 0 1 0 1",
                     bus.q, bus.tc, bus.busy, bus.zero);
        end
        step();
        total++;
        if ({bus.q, bus.tc, bus.busy} !== {16'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL zero_start_after: q=%0d tc=%0b busy=%0b, want 0 0 0", bus.q, bus.tc, bus.busy);
        end
    endtask

    task automatic test_stop_restart();
        logic [15:0] eq;
        bus.ld_val = 16'd10;
        bus.start  = 1'b1;
        bus.en     = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        total++;
        if ({bus.q, bus.busy} !== {16'd6, 1'b1}) begin
            bad++;
            $display("FAIL stop_prerun: q=%0d busy=%0b, want 6 1", bus.q, bus.busy);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        total++;
        if ({bus.q, bus.busy, bus.tc} !== {16'd6, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL stop_hold: q=%0d busy=%0b tc=%0b, want 6 0 0", bus.q, bus.busy, bus.tc);
        end
        step();
        step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        total++;
        if ({bus.q, bus.busy, bus.tc} !== {16'd6, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL idle_ignores_en_stop: q=%0d busy=%0b tc=%0b, want 6 0 0", bus.q, bus.busy, bus.tc);
        end
        bus.ld_val = 16'd10;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 7; i++) step();
        total++;
        if (bus.q !== 16'd3) begin
            bad++;
            $display("FAIL restart_prerun: q=%0d, want 3", bus.q);
        end
        bus.ld_val = 16'd8;
        bus.start  = 1'b1;
        bus.stop   = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        total++;
        if ({bus.q, bus.busy, bus.tc} !== {16'd8, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL restart_load: q=%0d busy=%0b tc=%0b, want 8 1 0", bus.q, bus.busy, bus.tc);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            eq = (i == 8) ? (RELOAD ? 16'd8 : 16'd0) : 16'(8 - i);
            total++;
            if ({bus.q, bus.tc} !== {eq, (i == 8)}) begin
                bad++;
                $display("FAIL restart_count[%0d]: q=%0d tc=%0b, want q=%0d tc=%0b", i, bus.q, bus.tc, eq, (i == 8));
            end
        end
        bus.en = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        bus.ld_val = 16'd10;
        bus.start  = 1'b1;
        bus.en     = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        total++;
        if (bus.q !== 16'd7) begin
            bad++;
            $display("FAIL areset_prerun: q=%0d, want 7", bus.q);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.q, bus.busy, bus.tc} !== {16'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL areset_immediate: q=%0d busy=%0b tc=%0b, want 0 0 0", bus.q, bus.busy, bus.tc);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if ({bus.q, bus.busy, bus.tc} !== {16'd0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL areset_after[%0d]: q=%0d busy=%0b tc=%0b, want 0 0 0", i, bus.q, bus.busy, bus.tc);
            end
        end
    endtask

`ifdef DCNT16_RELOAD_EN
    task automatic test_reload();
        logic [15:0] exp_q [7] = '{16'd2, 16'd1, 16'd3, 16'd2, 16'd1, 16'd3, 16'd2};
        bus.ld_val = 16'd3;
        bus.start  = 1'b1;
        bus.en     = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if ({bus.q, bus.busy} !== {16'd3, 1'b1}) begin
            bad++;
            $display("FAIL reload_load: q=%0d busy=%0b, want 3 1", bus.q, bus.busy);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            total++;
            if ({bus.q, bus.tc, bus.busy} !== {exp_q[i], (exp_q[i] == 16'd3), 1'b1}) begin
                bad++;
                $display("FAIL reload_count[%0d]: q=%0d tc=%0b busy=%0b, want q=%0d tc=%0b busy=1",
                         i, bus.q, bus.tc, bus.busy, exp_q[i], (exp_q[i] == 16'd3));
            end
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        total++;
        if ({bus.q, bus.busy, bus.tc} !== {16'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reload_stop: q=%0d busy=%0b tc=%0b, want 2 0 0", bus.q, bus.busy, bus.tc);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_en_toggle();
        test_zero_start();
        test_stop_restart();
        test_async_reset();
`ifdef DCNT16_RELOAD_EN
        test_reload();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
